cong_nbit_pipe: RTL

- Parametrised, pipelined successor of the 2-bit ripple adder: N-bit add/subtract, split into K-bit ripple chunks, one chunk per pipeline stage.
- Carry is registered between stages.
- Operands are skewed so each stage works on its own chunk.
- Valid/ready handshake on both sides with full back-pressure.
- Used as the shared arithmetic datapath for wider accumulators and ALUs, where the combinational ripple no longer meets timing.

---
 rtl/cong_pkg.sv | 10 +
 rtl/cong_1bit.sv | 16 +
 rtl/cong_kbit.sv | 33 +++
 rtl/cong_nbit_pipe.sv | 123 ++++++++++++
 4 files changed

// File: rtl/cong_pkg.sv
// Shared constants for the pipelined N-bit add/subtract datapath.
package cong_pkg;

  localparam int unsigned CONG_N_DEF = 8;
  localparam int unsigned CONG_K_DEF = 2;

  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;

endpackage

// File: rtl/cong_1bit.sv
// Single-bit full adder cell, the building block of every ripple chunk.
module cong_1bit (
  input  logic a_i,
  input  logic b_i,
  input  logic cin_i,
  output logic s_o,
  output logic cout_o
);

  // Sum and majority carry.
  always_comb begin
    s_o    = a_i ^ b_i ^ cin_i;
    cout_o = (a_i & b_i) | (cin_i & (a_i ^ b_i));
  end

endmodule

// File: rtl/cong_kbit.sv
// Combinational K-bit ripple adder built from cong_1bit cells. Also exports the
// carry into its MSB so the last pipeline stage can derive signed overflow.
module cong_kbit
  import cong_pkg::*;
#(
  parameter int unsigned K = CONG_K_DEF
) (
  input  logic [K-1:0] a_i,
  input  logic [K-1:0] b_i,
  input  logic         cin_i,
  output logic [K-1:0] s_o,
  output logic         cout_o,
  output logic         cmsb_o
);

  logic [K:0] carry;

  assign carry[0] = cin_i;

  for (genvar g = 0; g < K; g++) begin : g_bit
    cong_1bit u_bit (
      .a_i   (a_i[g]),
      .b_i   (b_i[g]),
      .cin_i (carry[g]),
      .s_o   (s_o[g]),
      .cout_o(carry[g+1])
    );
  end

  assign cout_o = carry[K];
  assign cmsb_o = carry[K-1];

endmodule

// File: rtl/cong_nbit_pipe.sv
// Pipelined N-bit add/subtract: one K-bit ripple chunk per stage, carry
// registered between stages, valid/ready handshake with full back-pressure.
module cong_nbit_pipe
  import cong_pkg::*;
#(
  parameter int unsigned N = CONG_N_DEF,
  parameter int unsigned K = CONG_K_DEF
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  input  logic         Cin,
  input  logic         sub,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] S,
  output logic         Cout,
  output logic         Ovf
);

  localparam int unsigned STAGES = N / K;

  if ((K == 0) || (N % K != 0)) begin : g_bad_split
    $error("cong_nbit_pipe: N (%0d) must be a non-zero multiple of K (%0d)", N, K);
  end

  // Each stage keeps one N-bit word per operand. The A word doubles as the
  // result: every stage drops its consumed low chunk, shifts right by K and
  // inserts its partial sum at the top, so after STAGES stages it holds S.
  logic [STAGES-1:0] valid_q, valid_d;
  logic [N-1:0]      a_q [STAGES];
  logic [N-1:0]      b_q [STAGES];
  logic [N-1:0]      a_d [STAGES];
  logic [N-1:0]      b_d [STAGES];
  logic [STAGES-1:0] carry_q;
  logic              ovf_q, ovf_d;

  logic [N-1:0]      a_src [STAGES];
  logic [N-1:0]      b_src [STAGES];
  logic [STAGES-1:0] c_src;

  logic [K-1:0]      chunk_s [STAGES];
  logic [STAGES-1:0] chunk_c;
  logic [STAGES-1:0] chunk_m;

  logic sub_mode;
  logic advance;

  assign sub_mode  = (sub == MODE_SUB);
  assign out_valid = valid_q[STAGES-1];
  assign advance   = !out_valid || out_ready;
  assign in_ready  = advance;

  assign S    = a_q[STAGES-1];
  assign Cout = carry_q[STAGES-1];
  assign Ovf  = ovf_q;

  // Stage inputs: stage 0 takes prepared operands, later stages the previous register.
  always_comb begin
    valid_d[0] = in_valid;
    a_src[0]   = A;
    b_src[0]   = B ^ {N{sub_mode}};
    c_src[0]   = Cin ^ sub_mode;
    for (int unsigned i = 1; i < STAGES; i++) begin
      valid_d[i] = valid_q[i-1];
      a_src[i]   = a_q[i-1];
      b_src[i]   = b_q[i-1];
      c_src[i]   = carry_q[i-1];
    end
  end

  for (genvar g = 0; g < STAGES; g++) begin : g_stage
    cong_kbit #(
      .K(K)
    ) u_chunk (
      .a_i   (a_src[g][K-1:0]),
      .b_i   (b_src[g][K-1:0]),
      .cin_i (c_src[g]),
      .s_o   (chunk_s[g]),
      .cout_o(chunk_c[g]),
      .cmsb_o(chunk_m[g])
    );
  end

  // Next words: drop the consumed chunk, park the partial sum at the top.
  always_comb begin
    for (int unsigned i = 0; i < STAGES; i++) begin
      a_d[i]            = a_src[i] >> K;
      a_d[i][N-1 -: K]  = chunk_s[i];
      b_d[i]            = b_src[i] >> K;
    end
    ovf_d = chunk_m[STAGES-1] ^ chunk_c[STAGES-1];
  end

  // Pipeline registers: the whole pipe shifts together whenever the output can move.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      carry_q <= '0;
      ovf_q   <= 1'b0;
      for (int unsigned i = 0; i < STAGES; i++) begin
        a_q[i] <= '0;
        b_q[i] <= '0;
      end
    end else if (advance) begin
      valid_q <= valid_d;
      carry_q <= chunk_c;
      ovf_q   <= ovf_d;
      for (int unsigned i = 0; i < STAGES; i++) begin
        a_q[i] <= a_d[i];
        b_q[i] <= b_d[i];
      end
    end
  end

  // The last B word and the non-final MSB carries have no consumer.
  logic unused_tail;
  assign unused_tail = ^{b_q[STAGES-1], chunk_m};

endmodule
